fpadd_arbiter: RTL and testbench
================================

# fpadd_arbiter

Two-requester arbiter and sequencer for the shared 32-bit floating-point adder pipeline. It accepts operand pairs from two independent clients over valid/ready handshakes and issues at most one operation per cycle to the adder. A tag shift register tracks each operation through the adder's fixed latency, and the result is steered into a per-requester result FIFO. Credit counting guarantees that no result ever arrives without FIFO space, because the adder pipeline cannot stall.

## Interface
Parameters:
- `ADD_LAT`, default 2: cycles from `fa_a`/`fa_b` being presented to `fa_result` being valid.
- `DEPTH`, default 4: result FIFO depth per requester; also the credit limit per requester. Must be a power of 2.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset_n`, input, 1: reset, synchronous and active-low.
- `req_valid`, input, 2: request valid, one bit per requester.
- `req_ready`, output, 2: request accepted on `req_valid & req_ready`.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`, input, 32 each: FP32 operands for requester 0 and requester 1.
- `req_op`, input, 2: per-requester op bit, 1 = subtract. Used only with `FPADD_ARB_SUB_EN`.
- `rsp_valid`, output, 2: result available at the head of that requester's FIFO.
- `rsp_ready`, input, 2: result consumed on `rsp_valid & rsp_ready`.
- `rsp_data0`, `rsp_data1`, output, 32 each: FIFO head data.
- `fa_a`, `fa_b`, output, 32 each: registered operands driven to the adder.
- `fa_result`, input, 32: adder output.

## Operation
- **Credits.** `cnt[i]` counts requester i's in-flight operations plus its FIFO occupancy, range 0..DEPTH.
  - Increments on accept; decrements on response handshake.
  - Accept and response in the same cycle leave it unchanged.
- **Eligibility.** Requester i is eligible when `req_valid[i]` is high and `cnt[i] < DEPTH`.
- **Round-robin arbitration.**
  - `last` records the last granted requester; reset value is 1, so requester 0 wins first.
  - Both eligible: grant `!last`. One eligible: grant it. `last` updates only on a grant.
  - `req_ready[i]` = grant to i. It may depend on `req_valid` of either requester; requesters must not make `req_valid` depend on `req_ready`.
- **Issue.** On accept, the selected operands are registered into `fa_a`/`fa_b`. Without a grant, `fa_a`/`fa_b` hold their last values; the result is ignored because the tag is invalid.
- **Tag pipe.** `ADD_LAT+1` stages, each holding {valid, id}, shifting every cycle. Stage 0 is loaded with {accept, granted id} at the same edge that loads `fa_a`/`fa_b`.
- **Result capture.** When the last stage is valid, `fa_result` is pushed into FIFO[id]. The credit scheme guarantees space; a push into a full FIFO is a design error and must be asserted in simulation.
- **FIFOs.** Per-requester, in-order, with read/write pointers plus a wrap bit. Push and pop in the same cycle are allowed, including when full (pop-then-push) and when empty (no pass-through).
- **Ordering.** Results for one requester return in acceptance order. No ordering relation holds across requesters.

## Timing
- **Reset values** (`reset_n` low at a rising edge): `req_ready`=0, `rsp_valid`=0, `rsp_data*`=0, `fa_a`/`fa_b`=0, all tags invalid, FIFOs empty, `cnt`=0, `last`=1.
- **Latency.** Request accepted in cycle t produces `rsp_valid` high in cycle t+ADD_LAT+2; with the default, accept in cycle 0 gives the response in cycle 4.
- **Throughput.** One accept per cycle total. Each of two continuously valid requesters gets every other cycle.
- **Backpressure.** A requester with `DEPTH` outstanding sees `req_ready`=0 until a response handshake. It regains `req_ready` in the cycle after that handshake.
- **Reset mid-operation.** In-flight tags and FIFO contents are discarded. Adder outputs arriving after reset release are ignored because their tags are cleared.

## Configuration
- **`FPADD_ARB_SUB_EN` defined:** when the accepted `req_op[i]`=1, `fa_b` is loaded with the sign bit of `req_b*` inverted, so the adder computes A−B.
- **Macro undefined:** `req_op` is ignored and all operations are additions. `fa_b` is the unmodified operand.

## Test plan
- **Single request:** reset, then req0 with A=0x3F800000, B=0x40000000 accepted in cycle 0 → `rsp_valid[0]` high in cycle 4 with `rsp_data0`=0x40400000; `rsp_valid[1]` stays 0.
- **Contention:** both requesters valid every cycle, `rsp_ready`=2'b11 → grants alternate 0,1,0,1 starting with 0; each requester's results return in its own issue order.
- **Backpressure:** `rsp_ready[1]`=0, req1 always valid → exactly 4 req1 accepts, then `req_ready[1]`=0 while req0 keeps being granted every cycle. Raising `rsp_ready[1]` drains 4 results in order and `req_ready[1]` returns the next cycle.
- **Subtract (macro on):** req_op=1, A=0x40400000, B=0x3F800000 → 0x40000000. Same stimulus with the macro off → 0x40800000.
- **Reset mid-op:** two operations in flight, pulse `reset_n` low for one cycle → no `rsp_valid` afterwards, `cnt`=0, and the next request is granted to requester 0.

Source files
------------

// File: rtl/fpadd_arbiter_if.sv
// Request, response and adder-side signals of the two-client FP adder arbiter.
// slave: the arbiter. master: the clients plus the adder pipeline.
interface fpadd_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [1:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data0;
  logic [31:0] rsp_data1;
  logic [31:0] fa_a;
  logic [31:0] fa_b;
  logic [31:0] fa_result;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op, rsp_ready, fa_result,
    output req_ready, rsp_valid, rsp_data0, rsp_data1, fa_a, fa_b
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op, rsp_ready, fa_result,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1, fa_a, fa_b
  );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter/sequencer for a shared fixed-latency FP32 adder with credit-checked
// per-requester result FIFOs. Define FPADD_ARB_SUB_EN to honour req_op (subtract).
module fpadd_arbiter #(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned DEPTH   = 4
) (
  input logic            clk,
  input logic            reset_n,
  fpadd_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NT = ADD_LAT + 1;

  logic [1:0]    elig, grant, push, pop, empty, full;
  logic          accept, gid, op_sub;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [31:0]   fa_a_q, fa_a_d, fa_b_q, fa_b_d, sel_a, sel_b;
  logic [NT-1:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic [AW:0]   wptr_q [2];
  logic [AW:0]   wptr_d [2];
  logic [AW:0]   rptr_q [2];
  logic [AW:0]   rptr_d [2];
  logic [31:0]   mem_q [2][DEPTH];
  logic [31:0]   mem_d [2][DEPTH];

  // Grants are suppressed while reset is asserted so nothing is accepted in that cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = bus.req_valid[i] && (cnt_q[i] < CW'(DEPTH));
    end
    grant = 2'b00;
    if (reset_n) begin
      if (elig == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else               grant = elig;
    end
    accept = |grant;
    gid    = grant[1];
    last_d = accept ? gid : last_q;
  end

`ifdef FPADD_ARB_SUB_EN
  assign op_sub = gid ? bus.req_op[1] : bus.req_op[0];
`else
  logic unused_req_op;
  assign unused_req_op = ^bus.req_op;
  assign op_sub        = 1'b0;
`endif

  always_comb begin
    sel_a     = gid ? bus.req_a1 : bus.req_a0;
    sel_b     = gid ? bus.req_b1 : bus.req_b0;
    fa_a_d    = accept ? sel_a : fa_a_q;
    fa_b_d    = accept ? {sel_b[31] ^ op_sub, sel_b[30:0]} : fa_b_q;
    tag_vld_d = {tag_vld_q[NT-2:0], accept};
    tag_id_d  = {tag_id_q[NT-2:0], gid};
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wptr_q[i] == rptr_q[i]);
      full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                 (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
      push[i]  = tag_vld_q[NT-1] && (tag_id_q[NT-1] == (i == 1));
      pop[i]   = !empty[i] && bus.rsp_ready[i];
      wptr_d[i] = wptr_q[i] + {{AW{1'b0}}, push[i]};
      rptr_d[i] = rptr_q[i] + {{AW{1'b0}}, pop[i]};
      cnt_d[i]  = cnt_q[i] + {{(CW-1){1'b0}}, grant[i]} - {{(CW-1){1'b0}}, pop[i]};
      if (push[i]) mem_d[i][wptr_q[i][AW-1:0]] = bus.fa_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q    <= 1'b1;
      fa_a_q    <= '0;
      fa_b_q    <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      last_q    <= last_d;
      fa_a_q    <= fa_a_d;
      fa_b_q    <= fa_b_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // Storage only; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = ~empty;
  assign bus.rsp_data0 = empty[0] ? 32'h0 : mem_q[0][rptr_q[0][AW-1:0]];
  assign bus.rsp_data1 = empty[1] ? 32'h0 : mem_q[1][rptr_q[1][AW-1:0]];
  assign bus.fa_a      = fa_a_q;
  assign bus.fa_b      = fa_b_q;

  // The adder cannot stall, so a result must never land in a full FIFO unless a pop frees it.
  push_into_full_a: assert property (@(posedge clk) disable iff (!reset_n)
    ((push & full & ~pop) == 2'b00));

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Self-checking bench for fpadd_arbiter: integer-valued FP32 operands, a behavioural adder
// and a queue-based reference of credits, round-robin grants and response timing.
module tb_fpadd_arbiter;
  localparam int unsigned ADD_LAT = 2;
  localparam int unsigned DEPTH   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpadd_arbiter_if bus ();

  fpadd_arbiter #(.ADD_LAT(ADD_LAT), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] mag, sh;
    int p;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int k = 0; k < 32; k++) if (mag[k]) p = k;
    sh = mag << (23 - p);
    return {v < 0, 8'(127 + p), sh[22:0]};
  endfunction

  function automatic int fp_to_int(input logic [31:0] x);
    int e;
    logic [31:0] m;
    if (x[30:23] == 8'h0) return 0;
    e = int'(x[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = {8'h0, 1'b1, x[22:0]} >> (23 - e);
    return x[31] ? -int'(m) : int'(m);
  endfunction

  // Adder: ADD_LAT register stages, exact for the small integers the bench uses.
  logic [31:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= int_to_fp(fp_to_int(bus.fa_a) + fp_to_int(bus.fa_b));
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign bus.fa_result = add_pipe[ADD_LAT-1];

  int ra [2];
  int rb [2];
  logic [1:0] reqv = 2'b00, rop = 2'b00, rrdy = 2'b00;
  int n_cmp = 0, n_fail = 0, cyc = 0;

  typedef struct {
    int          arrive;
    logic [31:0] data;
  } ent_t;
  ent_t q0[$];
  ent_t q1[$];
  logic       m_last = 1'b1;
  logic [1:0] m_grant;

  task automatic drive();
    bus.req_valid = reqv;
    bus.req_op    = rop;
    bus.rsp_ready = rrdy;
    bus.req_a0    = int_to_fp(ra[0]);
    bus.req_b0    = int_to_fp(rb[0]);
    bus.req_a1    = int_to_fp(ra[1]);
    bus.req_b1    = int_to_fp(rb[1]);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 2; i++) begin
      ra[i] = int'($urandom_range(0, 2000)) - 1000;
      rb[i] = int'($urandom_range(0, 2000)) - 1000;
    end
  endtask

  function automatic logic [31:0] exp_res(input int i);
    int r;
    r = ra[i] + rb[i];
`ifdef FPADD_ARB_SUB_EN
    if (rop[i]) r = ra[i] - rb[i];
`endif
    return int_to_fp(r);
  endfunction

  // Credit = entries held in the per-requester queue (in flight or buffered).
  task automatic model_expect(output logic [1:0] er, output logic [1:0] ev,
                              output logic [31:0] ed0, output logic [31:0] ed1);
    logic [1:0] el;
    el[0] = reqv[0] && (q0.size() < DEPTH);
    el[1] = reqv[1] && (q1.size() < DEPTH);
    if (el == 2'b11) er = m_last ? 2'b01 : 2'b10;
    else             er = el;
    m_grant = er;
    ev  = 2'b00;
    ed0 = 32'h0;
    ed1 = 32'h0;
    if (q0.size() > 0 && q0[0].arrive <= cyc) begin ev[0] = 1'b1; ed0 = q0[0].data; end
    if (q1.size() > 0 && q1[0].arrive <= cyc) begin ev[1] = 1'b1; ed1 = q1[0].data; end
  endtask

  task automatic model_commit(input logic [1:0] ev);
    ent_t e;
    if (ev[0] && rrdy[0]) void'(q0.pop_front());
    if (ev[1] && rrdy[1]) void'(q1.pop_front());
    e.arrive = cyc + ADD_LAT + 2;
    if (m_grant[0]) begin e.data = exp_res(0); q0.push_back(e); end
    if (m_grant[1]) begin e.data = exp_res(1); q1.push_back(e); end
    if (|m_grant) m_last = m_grant[1];
  endtask

  task automatic test_reset();
    reqv = 2'b11; rrdy = 2'b11; ra = '{1, 2}; rb = '{3, 4};
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset req_ready: got %b want 00", bus.req_ready);
    end
    if (bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset rsp_valid: got %b want 00", bus.rsp_valid);
    end
    if (bus.rsp_data0 !== 32'h0 || bus.rsp_data1 !== 32'h0) begin
      n_fail++; $display("FAIL reset rsp_data: got %h/%h want 0", bus.rsp_data0, bus.rsp_data1);
    end
    if (bus.fa_a !== 32'h0) begin
      n_fail++; $display("FAIL reset fa_a: got %h want 0", bus.fa_a);
    end
    if (bus.fa_b !== 32'h0) begin
      n_fail++; $display("FAIL reset fa_b: got %h want 0", bus.fa_b);
    end
    reqv = 2'b00;
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_contention();
    logic [1:0] er, ev;
    logic [31:0] ed0, ed1;
    for (int c = 0; c < 32; c++) begin
      randomize_ops();
      reqv = (c < 20) ? 2'b11 : 2'b00;
      rrdy = 2'b11;
      drive();
      @(negedge clk);
      model_expect(er, ev, ed0, ed1);
      n_cmp += 2;
      if (bus.req_ready !== er) begin
        n_fail++; $display("FAIL contention ready: got %b want %b cyc %0d", bus.req_ready, er, cyc);
      end
      if (bus.rsp_valid !== ev) begin
        n_fail++; $display("FAIL contention rsp_valid: got %b want %b cyc %0d", bus.rsp_valid, ev, cyc);
      end
      if (ev[0]) begin
        n_cmp++;
        if (bus.rsp_data0 !== ed0) begin
          n_fail++; $display("FAIL contention data0: got %h want %h", bus.rsp_data0, ed0);
        end
      end
      if (ev[1]) begin
        n_cmp++;
        if (bus.rsp_data1 !== ed1) begin
          n_fail++; $display("FAIL contention data1: got %h want %h", bus.rsp_data1, ed1);
        end
      end
      if (c < 20) begin
        n_cmp++;
        if (bus.req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL contention alternate: got %b at step %0d", bus.req_ready, c);
        end
      end
      model_commit(ev);
      next_cycle();
    end
  endtask

  // mode 0: single add 1+2; mode 1: 3 with op=1 and 1.
  task automatic test_single_op(input int mode);
    logic [1:0] er, ev;
    logic [31:0] ed0, ed1, want;
    want = 32'h40400000;
    if (mode == 1) begin
`ifdef FPADD_ARB_SUB_EN
      want = 32'h40000000;
`else
      want = 32'h40800000;
`endif
    end
    for (int c = 0; c < 10; c++) begin
      ra[0] = (mode == 0) ? 1 : 3;
      rb[0] = (mode == 0) ? 2 : 1;
      rop   = (mode == 0) ? 2'b00 : 2'b01;
      reqv  = (c == 0) ? 2'b01 : 2'b00;
      rrdy  = 2'b11;
      drive();
      @(negedge clk);
      model_expect(er, ev, ed0, ed1);
      n_cmp += 2;
      if (bus.req_ready !== er) begin
        n_fail++; $display("FAIL single%0d ready: got %b want %b step %0d", mode, bus.req_ready, er, c);
      end
      if (bus.rsp_valid !== ev) begin
        n_fail++; $display("FAIL single%0d rsp_valid: got %b want %b step %0d", mode, bus.rsp_valid, ev, c);
      end
      if (c == ADD_LAT + 2) begin
        n_cmp += 2;
        if (bus.rsp_valid !== 2'b01) begin
          n_fail++; $display("FAIL single%0d latency: rsp_valid %b want 01", mode, bus.rsp_valid);
        end
        if (bus.rsp_data0 !== want) begin
          n_fail++; $display("FAIL single%0d result: got %h want %h", mode, bus.rsp_data0, want);
        end
      end
      model_commit(ev);
      next_cycle();
    end
    rop = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [1:0] er, ev;
    logic [31:0] ed0, ed1;
    int acc1 = 0;
    for (int c = 0; c < 42; c++) begin
      randomize_ops();
      reqv = (c < 30) ? 2'b11 : 2'b00;
      rrdy = (c < 16) ? 2'b01 : 2'b11;
      drive();
      @(negedge clk);
      model_expect(er, ev, ed0, ed1);
      if (c < 16 && bus.req_ready[1]) acc1++;
      n_cmp += 2;
      if (bus.req_ready !== er) begin
        n_fail++; $display("FAIL backpressure ready: got %b want %b step %0d", bus.req_ready, er, c);
      end
      if (bus.rsp_valid !== ev) begin
        n_fail++; $display("FAIL backpressure rsp_valid: got %b want %b step %0d", bus.rsp_valid, ev, c);
      end
      if (ev[0]) begin
        n_cmp++;
        if (bus.rsp_data0 !== ed0) begin
          n_fail++; $display("FAIL backpressure data0: got %h want %h", bus.rsp_data0, ed0);
        end
      end
      if (ev[1]) begin
        n_cmp++;
        if (bus.rsp_data1 !== ed1) begin
          n_fail++; $display("FAIL backpressure data1: got %h want %h", bus.rsp_data1, ed1);
        end
      end
      model_commit(ev);
      next_cycle();
    end
    n_cmp++;
    if (acc1 !== int'(DEPTH)) begin
      n_fail++; $display("FAIL backpressure req1 accepts: got %0d want %0d", acc1, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [1:0] er, ev;
    logic [31:0] ed0, ed1;
    for (int c = 0; c < 312; c++) begin
      randomize_ops();
      reqv = (c < 300) ? 2'($urandom) : 2'b00;
      rop  = 2'($urandom);
      rrdy = (c < 300) ? 2'($urandom | $urandom) : 2'b11;
      drive();
      @(negedge clk);
      model_expect(er, ev, ed0, ed1);
      n_cmp += 2;
      if (bus.req_ready !== er) begin
        n_fail++; $display("FAIL random ready: got %b want %b cyc %0d", bus.req_ready, er, cyc);
      end
      if (bus.rsp_valid !== ev) begin
        n_fail++; $display("FAIL random rsp_valid: got %b want %b cyc %0d", bus.rsp_valid, ev, cyc);
      end
      if (ev[0]) begin
        n_cmp++;
        if (bus.rsp_data0 !== ed0) begin
          n_fail++; $display("FAIL random data0: got %h want %h cyc %0d", bus.rsp_data0, ed0, cyc);
        end
      end
      if (ev[1]) begin
        n_cmp++;
        if (bus.rsp_data1 !== ed1) begin
          n_fail++; $display("FAIL random data1: got %h want %h cyc %0d", bus.rsp_data1, ed1, cyc);
        end
      end
      model_commit(ev);
      next_cycle();
    end
    rop = 2'b00;
  endtask

  task automatic test_reset_midop();
    logic [1:0] er, ev;
    logic [31:0] ed0, ed1;
    int seen = 0, acc0 = 0;
    for (int c = 0; c < 40; c++) begin
      randomize_ops();
      reqv = (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : (c == 11) ? 2'b11 :
             (c >= 12 && c < 20) ? 2'b01 : 2'b00;
      rrdy = (c >= 12 && c < 20) ? 2'b00 : 2'b11;
      reset_n = (c != 2);
      drive();
      @(negedge clk);
      if (c == 2) begin
        q0.delete();
        q1.delete();
        m_last = 1'b1;
        next_cycle();
        continue;
      end
      model_expect(er, ev, ed0, ed1);
      if (c > 2 && c < 11 && bus.rsp_valid != 2'b00) seen++;
      if (c >= 12 && c < 20 && bus.req_ready[0]) acc0++;
      n_cmp += 2;
      if (bus.req_ready !== er) begin
        n_fail++; $display("FAIL midreset ready: got %b want %b step %0d", bus.req_ready, er, c);
      end
      if (bus.rsp_valid !== ev) begin
        n_fail++; $display("FAIL midreset rsp_valid: got %b want %b step %0d", bus.rsp_valid, ev, c);
      end
      if (ev[0]) begin
        n_cmp++;
        if (bus.rsp_data0 !== ed0) begin
          n_fail++; $display("FAIL midreset data0: got %h want %h", bus.rsp_data0, ed0);
        end
      end
      if (c == 11) begin
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
          n_fail++; $display("FAIL midreset first grant: got %b want 01", bus.req_ready);
        end
      end
      model_commit(ev);
      next_cycle();
    end
    n_cmp += 2;
    if (seen !== 0) begin
      n_fail++; $display("FAIL midreset stale rsp: got %0d cycles want 0", seen);
    end
    if (acc0 !== int'(DEPTH) - 1) begin
      // One credit is already taken by the step-11 accept.
      n_fail++; $display("FAIL midreset credits: got %0d accepts want %0d", acc0, DEPTH - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_single_op(0);
    test_single_op(1);
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
